multicycle_instr_dispatch: RTL and testbench
============================================

// Module: multicycle_instr_dispatch
// PURPOSE
//  Upstream stage of the multicycle opcode unit: fetches 8-bit instructions from a sync-read program ROM,
//  decodes opcode [7:4], retires NOP/HALT locally and issues GCD/MUL/DIV/MOD/RAND words downstream.
//  Holds each issued word stable until the opcode unit pulses done, then advances the PC.
//  One instruction in flight; no prefetch.
// PARAMETERS
//  PC_W            8    program counter / ROM address width
//  PROG_LEN        16   number of valid program words; retiring address PROG_LEN-1 ends program
//  TIMEOUT_CYCLES  255  watchdog limit in WAIT_DONE (only with MC_TIMEOUT_EN)
// PORTS
//  clock        in   1     system clock, rising edge
//  reset        in   1     asynchronous, active-high
//  run          in   1     level; high = execute, low = pause after current instruction
//  imem_rd_en   out  1     ROM read strobe; imem_rdata valid exactly 1 cycle later
//  imem_addr    out  PC_W  ROM address (= pc while imem_rd_en)
//  imem_rdata   in   8     ROM read data
//  issue_instr  out  8     instruction word to opcode unit; stable from ISSUE until done accepted
//  issue_valid  out  1     1-cycle pulse: new word on issue_instr
//  opcode_done  in   1     1-cycle pulse from opcode unit: issued instruction complete
//  pc           out  PC_W  address of current/next instruction
//  busy         out  1     high in any state except IDLE and HALT
//  halted       out  1     high in HALT
//  illegal_op   out  1     sticky; set on opcode 0110..1110
//  timeout      out  1     sticky; watchdog expiry (0 without MC_TIMEOUT_EN)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, pc=0, ir=8'h00, issue_instr=8'h00; all 1-bit outputs 0; imem_addr=0.
//  States: IDLE, FETCH, LATCH, DECODE, ISSUE, WAIT_DONE, HALT.
//  IDLE: run=1 -> FETCH; else stay.
//  FETCH: imem_rd_en=1, imem_addr=pc -> LATCH.
//  LATCH: ir <= imem_rdata -> DECODE.
//  DECODE on ir[7:4]:
//   0000 NOP: retire (see RETIRE), no issue.
//   0001..0101: issue_instr <= ir -> ISSUE.
//   1111 HALT: -> HALT, pc unchanged.
//   0110..1110: illegal_op <= 1 -> HALT, pc unchanged.
//  ISSUE: issue_valid=1 this cycle only -> WAIT_DONE. opcode_done in ISSUE ignored.
//  WAIT_DONE: hold issue_instr; opcode_done=1 -> RETIRE.
//  RETIRE (same edge as exit of DECODE/WAIT_DONE): if pc==PROG_LEN-1 -> HALT, pc unchanged;
//   else pc <= pc+1 (mod 2^PC_W), then run=1 -> FETCH, run=0 -> IDLE.
//  HALT: busy=0, halted=1; run=0 for >=1 cycle -> IDLE with pc<=0, illegal_op/timeout cleared.
//   run held high stays in HALT.
//  run dropping mid-instruction never aborts; takes effect only at RETIRE.
//  opcode_done outside WAIT_DONE: ignored, no state change.
//  Latency: NOP = 3 cycles FETCH->next FETCH; issued op = 4 + N cycles (N = done delay after ISSUE, N>=1).
//  issue_instr retains last issued word after retire until next ISSUE.
// CONFIGURATION
//  MC_TIMEOUT_EN defined: PC_W-independent 16-bit counter cleared on ISSUE, incremented in WAIT_DONE.
//   On reaching TIMEOUT_CYCLES without opcode_done: timeout<=1, -> HALT, pc unchanged. done on limit cycle wins.
//  MC_TIMEOUT_EN undefined: no counter; WAIT_DONE waits indefinitely; timeout tied 0.
// TESTING
//  ROM {8'h00,8'h00,8'hF0}, run=1 -> HALT after 2 NOPs, pc=2, no issue_valid, 3 cycles/NOP.
//  ROM[0]=8'h21, done 5 cycles after issue_valid -> issue_instr=8'h21 held 5 cycles, pc 0->1.
//  ROM[0]=8'h7A -> illegal_op=1, halted=1, pc=0; run low 1 cycle then high -> restart at pc=0, flag cleared.
//  PROG_LEN=4, ROM all 8'h00 -> halt with pc=3; opcode_done pulses while in HALT -> no change.
//  run=0 during WAIT_DONE of 8'h35, then done -> IDLE, pc=1; run=1 -> FETCH at pc=1.
//  MC_TIMEOUT_EN, TIMEOUT_CYCLES=10, ROM[0]=8'h42, no done -> timeout=1, HALT 10 cycles after ISSUE;
//   async reset asserted mid-WAIT_DONE -> all outputs at reset values same cycle.

Source files
------------

// File: rtl/multicycle_instr_dispatch_if.sv
// Instruction-memory and issue handshake bundle between the dispatcher (master)
// and the program ROM / multicycle opcode unit (slave).
interface multicycle_instr_dispatch_if #(
  parameter int PC_W = 8
);
  logic            imem_rd_en;
  logic [PC_W-1:0] imem_addr;
  logic [7:0]      imem_rdata;
  logic [7:0]      issue_instr;
  logic            issue_valid;
  logic            opcode_done;

  modport master (
    output imem_rd_en,
    output imem_addr,
    input  imem_rdata,
    output issue_instr,
    output issue_valid,
    input  opcode_done
  );

  modport slave (
    input  imem_rd_en,
    input  imem_addr,
    output imem_rdata,
    input  issue_instr,
    input  issue_valid,
    output opcode_done
  );
endinterface

// File: rtl/multicycle_instr_dispatch.sv
// Dispatch front end for the multicycle opcode unit: fetch, decode, issue, wait for done.
// Optional WAIT_DONE watchdog is compiled in by defining MC_TIMEOUT_EN.
module multicycle_instr_dispatch #(
  parameter int PC_W           = 8,
  parameter int PROG_LEN       = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        run,
  multicycle_instr_dispatch_if.master bus,
  output logic [PC_W-1:0]             pc,
  output logic                        busy,
  output logic                        halted,
  output logic                        illegal_op,
  output logic                        timeout
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_LATCH     = 3'd2,
    ST_DECODE    = 3'd3,
    ST_ISSUE     = 3'd4,
    ST_WAIT_DONE = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

  localparam logic [PC_W-1:0] LAST_PC = PC_W'(PROG_LEN - 1);
  localparam logic [PC_W-1:0] PC_ONE  = PC_W'(1);

  state_t          state_r;
  state_t          state_s;
  state_t          retire_state_s;
  logic [PC_W-1:0] pc_r;
  logic [PC_W-1:0] pc_s;
  logic [PC_W-1:0] retire_pc_s;
  logic [7:0]      ir_r;
  logic [7:0]      ir_s;
  logic [7:0]      issue_instr_r;
  logic [7:0]      issue_instr_s;
  logic            illegal_r;
  logic            illegal_s;
  logic            timeout_r;
  logic            timeout_s;
  logic            imem_rd_en_r;
  logic            issue_valid_r;
  logic            busy_r;
  logic            halted_r;

`ifdef MC_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] wd_cnt_r;

  // Watchdog counter: cleared while issuing, counts every WAIT_DONE cycle
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wd_cnt_r <= 16'd0;
    end else if (state_r == ST_ISSUE) begin
      wd_cnt_r <= 16'd0;
    end else if (state_r == ST_WAIT_DONE) begin
      wd_cnt_r <= wd_cnt_r + 16'd1;
    end else begin
      wd_cnt_r <= wd_cnt_r;
    end
  end
`endif

  // Retire target: the last program word ends the program, otherwise advance and honour run
  always_comb begin
    if (pc_r == LAST_PC) begin
      retire_state_s = ST_HALT;
      retire_pc_s    = pc_r;
    end else begin
      retire_pc_s = pc_r + PC_ONE;
      if (run) begin
        retire_state_s = ST_FETCH;
      end else begin
        retire_state_s = ST_IDLE;
      end
    end
  end

  // Next-state, program counter and sticky flag logic
  always_comb begin
    state_s       = state_r;
    pc_s          = pc_r;
    ir_s          = ir_r;
    issue_instr_s = issue_instr_r;
    illegal_s     = illegal_r;
    timeout_s     = timeout_r;
    case (state_r)
      ST_IDLE: begin
        if (run) begin
          state_s = ST_FETCH;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        state_s = ST_LATCH;
      end
      ST_LATCH: begin
        ir_s    = bus.imem_rdata;
        state_s = ST_DECODE;
      end
      ST_DECODE: begin
        case (ir_r[7:4])
          4'h0: begin
            state_s = retire_state_s;
            pc_s    = retire_pc_s;
          end
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            issue_instr_s = ir_r;
            state_s       = ST_ISSUE;
          end
          4'hF: begin
            state_s = ST_HALT;
          end
          default: begin
            illegal_s = 1'b1;
            state_s   = ST_HALT;
          end
        endcase
      end
      ST_ISSUE: begin
        state_s = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // A done arriving on the watchdog limit cycle still retires normally
        if (bus.opcode_done) begin
          state_s = retire_state_s;
          pc_s    = retire_pc_s;
        end else begin
`ifdef MC_TIMEOUT_EN
          if (wd_cnt_r == TIMEOUT_LAST) begin
            timeout_s = 1'b1;
            state_s   = ST_HALT;
          end else begin
            state_s = ST_WAIT_DONE;
          end
`else
          state_s = ST_WAIT_DONE;
`endif
        end
      end
      ST_HALT: begin
        if (!run) begin
          state_s   = ST_IDLE;
          pc_s      = {PC_W{1'b0}};
          illegal_s = 1'b0;
          timeout_s = 1'b0;
        end else begin
          state_s = ST_HALT;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Architectural state registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      pc_r          <= {PC_W{1'b0}};
      ir_r          <= 8'h00;
      issue_instr_r <= 8'h00;
      illegal_r     <= 1'b0;
      timeout_r     <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      ir_r          <= ir_s;
      issue_instr_r <= issue_instr_s;
      illegal_r     <= illegal_s;
      timeout_r     <= timeout_s;
    end
  end

  // Status strobes registered from the next state so they align with the state they describe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      imem_rd_en_r  <= 1'b0;
      issue_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      halted_r      <= 1'b0;
    end else begin
      imem_rd_en_r  <= (state_s == ST_FETCH);
      issue_valid_r <= (state_s == ST_ISSUE);
      busy_r        <= (state_s != ST_IDLE) && (state_s != ST_HALT);
      halted_r      <= (state_s == ST_HALT);
    end
  end

  assign bus.imem_rd_en  = imem_rd_en_r;
  assign bus.imem_addr   = pc_r;
  assign bus.issue_instr = issue_instr_r;
  assign bus.issue_valid = issue_valid_r;
  assign pc              = pc_r;
  assign busy            = busy_r;
  assign halted          = halted_r;
  assign illegal_op      = illegal_r;
  assign timeout         = timeout_r;

endmodule

// File: tb/tb_multicycle_instr_dispatch.sv
// Bench for multicycle_instr_dispatch: directed table, hand-written corner sequences,
// and random programs scored against a program-level reference model.
module tb_multicycle_instr_dispatch;
  localparam int PC_W     = 8;
  localparam int PROG_LEN = 8;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic            run   = 1'b0;
  logic [PC_W-1:0] pc;
  logic            busy;
  logic            halted;
  logic            illegal_op;
  logic            timeout;

  multicycle_instr_dispatch_if #(.PC_W(PC_W)) bus ();

  multicycle_instr_dispatch #(
    .PC_W(PC_W), .PROG_LEN(PROG_LEN), .TIMEOUT_CYCLES(255)
  ) dut (
    .clock(clock), .reset(reset), .run(run), .bus(bus),
    .pc(pc), .busy(busy), .halted(halted), .illegal_op(illegal_op), .timeout(timeout)
  );

  always #5 clock = ~clock;

  logic [7:0] rom [256];
  always @(posedge clock) begin
    if (bus.imem_rd_en) bus.imem_rdata <= rom[bus.imem_addr];
  end

  int checks = 0;
  int errors = 0;
  int dly [64];
  logic [PC_W-1:0] fetch_q [$];
  logic [PC_W-1:0] exp_q [$];

  typedef struct {
    logic [7:0] w0, w1, w2;
    int         dly;
    int         exp_pc;
    int         exp_cyc;
    int         exp_nis;
    logic [7:0] exp_last;
    logic       exp_ill;
  } vec_t;
  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    run = 1'b0;
    bus.opcode_done = 1'b0;
    @(negedge clock); reset = 1'b1;
    @(negedge clock); reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic clear_rom();
    for (int j = 0; j < 256; j++) rom[j] = 8'h00;
  endtask

  task automatic wait_halted(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clock); #1;
      if (halted) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_valid(input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clock); #1;
      if (bus.issue_valid) begin ok = 1'b1; break; end
    end
  endtask

  // Runs from IDLE with run=1 until halted; plays the opcode unit using dly[], optionally
  // sprinkling opcode_done pulses wherever the dispatcher is not waiting for one.
  task automatic exec_prog(input int budget, input bit noise, output int cyc, output int nis,
                           output logic [7:0] last, output bit stable_ok, output bit finished);
    int f0 = -1;
    int issue_c = -1;
    int done_at = -1;
    logic [7:0] held = 8'h00;
    cyc = -1; nis = 0; last = 8'h00; stable_ok = 1'b1; finished = 1'b0;
    fetch_q.delete();
    run = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(posedge clock); #1;
      if (bus.imem_rd_en) begin
        if (f0 < 0) f0 = c;
        fetch_q.push_back(bus.imem_addr);
      end
      if (issue_c >= 0 && c > issue_c && c <= done_at && bus.issue_instr !== held) stable_ok = 1'b0;
      if (bus.issue_valid) begin
        issue_c = c;
        held = bus.issue_instr;
        last = held;
        done_at = c + dly[nis % 64];
        nis++;
      end
      if (halted) begin
        cyc = c - f0;
        finished = 1'b1;
        break;
      end
      if (c == done_at) bus.opcode_done = 1'b1;
      else if (noise && !(issue_c >= 0 && c > issue_c && c < done_at))
        bus.opcode_done = ($urandom_range(0, 3) == 0);
      else bus.opcode_done = 1'b0;
    end
    bus.opcode_done = 1'b0;
  endtask

  // Program-level model: walk the ROM instruction by instruction with run held high.
  task automatic ref_model(output int cyc, output int nis, output logic [7:0] last,
                           output int fpc, output bit ill);
    int p = 0;
    logic [7:0] w;
    logic [3:0] op;
    cyc = 0; nis = 0; last = 8'h00; ill = 1'b0;
    exp_q.delete();
    for (int guard = 0; guard < PROG_LEN; guard++) begin
      exp_q.push_back(PC_W'(p));
      w = rom[p];
      op = w[7:4];
      if (op == 4'hF) begin cyc += 3; break; end
      if (op >= 4'h6) begin ill = 1'b1; cyc += 3; break; end
      if (op == 4'h0) cyc += 3;
      else begin cyc += 4 + dly[nis]; last = w; nis++; end
      if (p == PROG_LEN - 1) break;
      p++;
    end
    fpc = p;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, nis, e_cyc, e_nis, e_pc;
    logic [7:0] last, e_last;
    bit stable_ok, finished, ok, e_ill, same;
    logic [3:0] op;

    vecs[0] = '{8'h00, 8'h00, 8'hF0, 1, 2, 9,  0, 8'h00, 1'b0};
    vecs[1] = '{8'h21, 8'hF0, 8'hF0, 5, 1, 12, 1, 8'h21, 1'b0};
    vecs[2] = '{8'h7A, 8'h00, 8'h00, 1, 0, 3,  0, 8'h00, 1'b1};
    vecs[3] = '{8'hF3, 8'h00, 8'h00, 1, 0, 3,  0, 8'h00, 1'b0};
    vecs[4] = '{8'h55, 8'hE3, 8'h00, 1, 1, 8,  1, 8'h55, 1'b1};
    vecs[5] = '{8'h10, 8'h00, 8'hF0, 2, 2, 12, 1, 8'h10, 1'b0};
    vecs[6] = '{8'h60, 8'h00, 8'h00, 1, 0, 3,  0, 8'h00, 1'b1};
    vecs[7] = '{8'hEF, 8'h00, 8'h00, 1, 0, 3,  0, 8'h00, 1'b1};
    vecs[8] = '{8'h0F, 8'h5C, 8'hF0, 3, 2, 13, 1, 8'h5C, 1'b0};

    // Asynchronous reset before any clock edge
    bus.opcode_done = 1'b0;
    clear_rom();
    #2 reset = 1'b1;
    #1;
    chk("rst_pc", pc, 0);
    chk("rst_flags", {busy, halted, illegal_op, timeout}, 4'b0000);
    chk("rst_strobes", {bus.imem_rd_en, bus.issue_valid}, 2'b00);
    chk("rst_issue_instr", bus.issue_instr, 8'h00);
    chk("rst_imem_addr", bus.imem_addr, 0);
    @(negedge clock); reset = 1'b0;

    // Directed single/short program table
    for (int i = 0; i < 9; i++) begin
      do_reset();
      clear_rom();
      rom[0] = vecs[i].w0; rom[1] = vecs[i].w1; rom[2] = vecs[i].w2;
      for (int j = 0; j < 64; j++) dly[j] = vecs[i].dly;
      exec_prog(100, 1'b0, cyc, nis, last, stable_ok, finished);
      chk($sformatf("v%0d_halted", i), finished, 1);
      chk($sformatf("v%0d_cycles", i), cyc, vecs[i].exp_cyc);
      chk($sformatf("v%0d_issues", i), nis, vecs[i].exp_nis);
      chk($sformatf("v%0d_last_issue", i), last, vecs[i].exp_last);
      chk($sformatf("v%0d_pc", i), pc, vecs[i].exp_pc);
      chk($sformatf("v%0d_illegal", i), illegal_op, vecs[i].exp_ill);
      chk($sformatf("v%0d_issue_hold", i), stable_ok, 1);
      chk($sformatf("v%0d_retain", i), bus.issue_instr, vecs[i].exp_last);
      chk($sformatf("v%0d_busy", i), busy, 0);
    end

    // run dropped during WAIT_DONE: retire to IDLE, then resume at the next pc
    do_reset();
    clear_rom();
    rom[0] = 8'h35; rom[1] = 8'hF0;
    run = 1'b1;
    wait_valid(20, ok);
    chk("A_issue_seen", ok, 1);
    run = 1'b0;
    repeat (3) begin @(posedge clock); #1; end
    chk("A_busy_wait", busy, 1);
    bus.opcode_done = 1'b1;
    @(posedge clock); #1;
    bus.opcode_done = 1'b0;
    chk("A_idle_busy", busy, 0);
    chk("A_idle_halted", halted, 0);
    chk("A_pc", pc, 1);
    chk("A_retain", bus.issue_instr, 8'h35);
    repeat (2) begin @(posedge clock); #1; end
    chk("A_no_fetch", bus.imem_rd_en, 0);
    run = 1'b1;
    @(posedge clock); #1;
    chk("A_refetch", bus.imem_rd_en, 1);
    chk("A_refetch_addr", bus.imem_addr, 1);
    wait_halted(10, ok);
    chk("A_halt", ok, 1);

    // Illegal opcode, done pulses while halted, restart via run low
    do_reset();
    clear_rom();
    rom[0] = 8'h7A;
    run = 1'b1;
    wait_halted(10, ok);
    chk("B_halt", ok, 1);
    chk("B_illegal", illegal_op, 1);
    chk("B_pc", pc, 0);
    repeat (3) begin
      bus.opcode_done = 1'b1;
      @(posedge clock); #1;
    end
    bus.opcode_done = 1'b0;
    chk("B_hold_halted", {halted, busy, bus.imem_rd_en, bus.issue_valid}, 4'b1000);
    run = 1'b0;
    @(posedge clock); #1;
    chk("B_exit_halted", halted, 0);
    chk("B_exit_illegal", illegal_op, 0);
    chk("B_exit_pc", pc, 0);
    run = 1'b1;
    @(posedge clock); #1;
    chk("B_restart_fetch", {bus.imem_rd_en, bus.imem_addr}, {1'b1, 8'h00});
    wait_halted(10, ok);
    chk("B_reillegal", {ok, illegal_op}, 2'b11);

    // All-NOP program runs to the last address
    do_reset();
    clear_rom();
    for (int j = 0; j < 64; j++) dly[j] = 1;
    exec_prog(200, 1'b1, cyc, nis, last, stable_ok, finished);
    chk("C_halted", finished, 1);
    chk("C_cycles", cyc, 3 * PROG_LEN);
    chk("C_pc", pc, PROG_LEN - 1);
    repeat (2) begin
      bus.opcode_done = 1'b1;
      @(posedge clock); #1;
    end
    bus.opcode_done = 1'b0;
    chk("C_hold_pc", pc, PROG_LEN - 1);
    chk("C_hold_halted", halted, 1);

    // Asynchronous reset during WAIT_DONE
    do_reset();
    clear_rom();
    rom[1] = 8'h21;
    run = 1'b1;
    wait_valid(20, ok);
    chk("D_issue_seen", ok, 1);
    @(posedge clock); #1;
    chk("D_wait_state", {busy, pc}, {1'b1, 8'h01});
    #2 reset = 1'b1;
    #1;
    chk("D_rst_pc", pc, 0);
    chk("D_rst_flags", {busy, halted, illegal_op, timeout, bus.imem_rd_en, bus.issue_valid}, 6'b000000);
    chk("D_rst_issue_instr", bus.issue_instr, 8'h00);
    @(negedge clock); reset = 1'b0;

    // Random programs against the reference model
    for (int t = 0; t < 25; t++) begin
      do_reset();
      clear_rom();
      for (int j = 0; j < PROG_LEN; j++) begin
        int r;
        r = $urandom_range(0, 19);
        if (r < 6) op = 4'h0;
        else if (r < 16) op = 4'($urandom_range(1, 5));
        else if (r < 18) op = 4'hF;
        else op = 4'($urandom_range(6, 14));
        rom[j] = {op, 4'($urandom_range(0, 15))};
      end
      for (int j = 0; j < 64; j++) dly[j] = $urandom_range(1, 6);
      ref_model(e_cyc, e_nis, e_last, e_pc, e_ill);
      exec_prog(400, 1'b1, cyc, nis, last, stable_ok, finished);
      chk($sformatf("r%0d_halted", t), finished, 1);
      chk($sformatf("r%0d_cycles", t), cyc, e_cyc);
      chk($sformatf("r%0d_issues", t), nis, e_nis);
      chk($sformatf("r%0d_last_issue", t), last, e_last);
      chk($sformatf("r%0d_pc", t), pc, e_pc);
      chk($sformatf("r%0d_illegal", t), illegal_op, e_ill);
      chk($sformatf("r%0d_issue_hold", t), stable_ok, 1);
      chk($sformatf("r%0d_retain", t), bus.issue_instr, e_last);
      same = (fetch_q.size() == exp_q.size());
      if (same) begin
        foreach (exp_q[k]) if (fetch_q[k] !== exp_q[k]) same = 1'b0;
      end
      chk($sformatf("r%0d_fetch_seq", t), same, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
